// File: rtl/calc1_top.sv
// -----------------------------------------------------------------------------
// calc1_top: four-port 32-bit unsigned integer calculator.
//
// Each requester port sends a two-cycle request. The first cycle carries the
// command and operand1, and the second carries operand2. The port answers with
// a one-cycle response code and result.
//
// Two execution units are shared by all four ports:
//   - add/sub unit: commands 1 and 2
//   - shift unit:   commands 5 and 6
// Each unit grants the lowest-numbered pending port that targets it.
// Invalid commands use no unit and are answered as soon as they are pending.
//
// Ports:
//   c_clk                 functional clock, rising edge
//   reset                 asynchronous active-low reset
//   a_clk, b_clk, scan_in scan interface, functionally ignored
//   scan_out              constant 0
//   error_found[0:3]      reserved debug control, ignored
//   reqN_cmd_in[0:3]      command (0 idle, 1 add, 2 sub, 5 shl, 6 shr)
//   reqN_data_in[0:31]    operand1 in the command cycle, operand2 the next cycle
//   out_respN[0:1]        0 none, 1 ok, 2 overflow/underflow, 3 invalid
//   out_dataN[0:31]       result when out_respN == 1, else 0
//   Bit 0 of every bus is the MSB.
// -----------------------------------------------------------------------------
module calc1_top (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        a_clk,
  input  logic        b_clk,
  input  logic        scan_in,
  output logic        scan_out,
  input  logic [0:3]  error_found,
  input  logic [0:3]  req1_cmd_in,
  input  logic [0:31] req1_data_in,
  input  logic [0:3]  req2_cmd_in,
  input  logic [0:31] req2_data_in,
  input  logic [0:3]  req3_cmd_in,
  input  logic [0:31] req3_data_in,
  input  logic [0:3]  req4_cmd_in,
  input  logic [0:31] req4_data_in,
  output logic [0:1]  out_resp1,
  output logic [0:31] out_data1,
  output logic [0:1]  out_resp2,
  output logic [0:31] out_data2,
  output logic [0:1]  out_resp3,
  output logic [0:31] out_data3,
  output logic [0:1]  out_resp4,
  output logic [0:31] out_data4
);

  typedef enum logic [1:0] {S_IDLE, S_OP2, S_PEND} state_t;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  localparam logic [1:0] RESP_OK  = 2'd1;
  localparam logic [1:0] RESP_OVF = 2'd2;
  localparam logic [1:0] RESP_INV = 2'd3;

  // Scan and debug inputs exist only for interface compatibility.
  logic unused_inputs;
  assign unused_inputs = ^{a_clk, b_clk, scan_in, error_found};
  assign scan_out      = 1'b0;

  function automatic logic is_as(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB);
  endfunction

  function automatic logic is_sh(input logic [3:0] cmd);
    return (cmd == CMD_SHL) || (cmd == CMD_SHR);
  endfunction

  // Returns {resp, data}. An overflow or underflow reports code 2 with
  // zero data.
  function automatic logic [33:0] exec_as(input logic [3:0] cmd,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (cmd == CMD_ADD) begin
      if (sum[32]) return {RESP_OVF, 32'd0};
      else         return {RESP_OK, sum[31:0]};
    end else begin
      if (b > a) return {RESP_OVF, 32'd0};
      else       return {RESP_OK, a - b};
    end
  endfunction

  // Logical shifts by the low five bits of operand2; always succeed.
  function automatic logic [33:0] exec_sh(input logic [3:0] cmd,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    if (cmd == CMD_SHL) return {RESP_OK, a << b[4:0]};
    else                return {RESP_OK, a >> b[4:0]};
  endfunction

  // Internal [31:0] views of the big-endian port buses. The numeric value
  // is unchanged.
  logic [3:0]  cmd_w  [4];
  logic [31:0] data_w [4];
  assign cmd_w[0]  = req1_cmd_in;
  assign cmd_w[1]  = req2_cmd_in;
  assign cmd_w[2]  = req3_cmd_in;
  assign cmd_w[3]  = req4_cmd_in;
  assign data_w[0] = req1_data_in;
  assign data_w[1] = req2_data_in;
  assign data_w[2] = req3_data_in;
  assign data_w[3] = req4_data_in;

  state_t      state_q [4], state_d [4];
  logic [3:0]  cmd_q   [4], cmd_d   [4];
  logic [31:0] op1_q   [4], op1_d   [4];
  logic [31:0] op2_q   [4], op2_d   [4];
  logic [1:0]  resp_q  [4], resp_d  [4];
  logic [31:0] res_q   [4], res_d   [4];

  // Fixed-priority grant. The loop runs from port 4 down to port 1, so the
  // lowest-numbered pending port is the last one written and wins.
  logic [1:0]  gnt_as_idx, gnt_sh_idx;
  logic        gnt_as_vld, gnt_sh_vld;
  logic [33:0] as_out, sh_out;

  always_comb begin
    gnt_as_idx = 2'd0;
    gnt_sh_idx = 2'd0;
    gnt_as_vld = 1'b0;
    gnt_sh_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (state_q[i] == S_PEND && is_as(cmd_q[i])) begin
        gnt_as_idx = 2'(i);
        gnt_as_vld = 1'b1;
      end
      if (state_q[i] == S_PEND && is_sh(cmd_q[i])) begin
        gnt_sh_idx = 2'(i);
        gnt_sh_vld = 1'b1;
      end
    end
    as_out = exec_as(cmd_q[gnt_as_idx], op1_q[gnt_as_idx], op2_q[gnt_as_idx]);
    sh_out = exec_sh(cmd_q[gnt_sh_idx], op1_q[gnt_sh_idx], op2_q[gnt_sh_idx]);
  end

  // Per-port request FSM and response staging. A response register holds a
  // value for exactly one cycle because it defaults back to zero.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state_q[i];
      cmd_d[i]   = cmd_q[i];
      op1_d[i]   = op1_q[i];
      op2_d[i]   = op2_q[i];
      resp_d[i]  = 2'd0;
      res_d[i]   = 32'd0;
      case (state_q[i])
        S_IDLE: begin
          if (cmd_w[i] != 4'd0) begin
            cmd_d[i]   = cmd_w[i];
            op1_d[i]   = data_w[i];
            state_d[i] = S_OP2;
          end
        end
        S_OP2: begin
          op2_d[i]   = data_w[i];
          state_d[i] = S_PEND;
        end
        S_PEND: begin
          if (!is_as(cmd_q[i]) && !is_sh(cmd_q[i])) begin
            resp_d[i]  = RESP_INV;
            state_d[i] = S_IDLE;
          end else if (gnt_as_vld && gnt_as_idx == 2'(i)) begin
            {resp_d[i], res_d[i]} = as_out;
            state_d[i]            = S_IDLE;
          end else if (gnt_sh_vld && gnt_sh_idx == 2'(i)) begin
            {resp_d[i], res_d[i]} = sh_out;
            state_d[i]            = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= S_IDLE;
        cmd_q[i]   <= 4'd0;
        op1_q[i]   <= 32'd0;
        op2_q[i]   <= 32'd0;
        resp_q[i]  <= 2'd0;
        res_q[i]   <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        state_q[i] <= state_d[i];
        cmd_q[i]   <= cmd_d[i];
        op1_q[i]   <= op1_d[i];
        op2_q[i]   <= op2_d[i];
        resp_q[i]  <= resp_d[i];
        res_q[i]   <= res_d[i];
      end
    end
  end

  assign out_resp1 = resp_q[0];
  assign out_resp2 = resp_q[1];
  assign out_resp3 = resp_q[2];
  assign out_resp4 = resp_q[3];
  assign out_data1 = res_q[0];
  assign out_data2 = res_q[1];
  assign out_data3 = res_q[2];
  assign out_data4 = res_q[3];

endmodule

// File: tb/tb_calc1_top.sv
module tb_calc1_top;

  logic        c_clk;
  logic        reset;
  logic        a_clk, b_clk, scan_in;
  logic        scan_out;
  logic [0:3]  error_found;
  logic [0:3]  cmd  [4];
  logic [0:31] din  [4];
  logic [0:1]  resp [4];
  logic [0:31] dout [4];

  int n_cmp;
  int n_bad;

  calc1_top dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .a_clk        (a_clk),
    .b_clk        (b_clk),
    .scan_in      (scan_in),
    .scan_out     (scan_out),
    .error_found  (error_found),
    .req1_cmd_in  (cmd[0]),
    .req1_data_in (din[0]),
    .req2_cmd_in  (cmd[1]),
    .req2_data_in (din[1]),
    .req3_cmd_in  (cmd[2]),
    .req3_data_in (din[2]),
    .req4_cmd_in  (cmd[3]),
    .req4_data_in (din[3]),
    .out_resp1    (resp[0]),
    .out_data1    (dout[0]),
    .out_resp2    (resp[1]),
    .out_data2    (dout[1]),
    .out_resp3    (resp[2]),
    .out_data3    (dout[2]),
    .out_resp4    (resp[3]),
    .out_data4    (dout[3])
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Check every port's response and data against expected values.
  task automatic chk_all(input string tag,
                         input logic [1:0] r0, input logic [31:0] d0,
                         input logic [1:0] r1, input logic [31:0] d1,
                         input logic [1:0] r2, input logic [31:0] d2,
                         input logic [1:0] r3, input logic [31:0] d3);
    chk({tag, "_resp1"}, 32'(resp[0]), 32'(r0));
    chk({tag, "_data1"}, dout[0], d0);
    chk({tag, "_resp2"}, 32'(resp[1]), 32'(r1));
    chk({tag, "_data2"}, dout[1], d1);
    chk({tag, "_resp3"}, 32'(resp[2]), 32'(r2));
    chk({tag, "_data3"}, dout[2], d2);
    chk({tag, "_resp4"}, 32'(resp[3]), 32'(r3));
    chk({tag, "_data4"}, dout[3], d3);
  endtask

  // Inputs change on falling edges. Returns at the falling edge after the
  // operand2 capture edge.
  task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge c_clk);
    cmd[p] = c;
    din[p] = a;
    @(negedge c_clk);
    cmd[p] = 4'd0;
    din[p] = b;
    @(negedge c_clk);
    din[p] = 32'd0;
  endtask

  // Single uncontended transaction. The response must be absent right after
  // operand2, present for one cycle, then gone.
  task automatic txn(input string tag, input int p, input logic [3:0] c,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [1:0] er, input logic [31:0] ed);
    issue(p, c, a, b);
    chk({tag, "_early"}, 32'(resp[p]), 32'd0);
    @(negedge c_clk);
    chk({tag, "_resp"}, 32'(resp[p]), 32'(er));
    chk({tag, "_data"}, dout[p], ed);
    @(negedge c_clk);
    chk({tag, "_clear"}, 32'(resp[p]), 32'd0);
  endtask

  initial begin
    n_cmp       = 0;
    n_bad       = 0;
    a_clk       = 1'b0;
    b_clk       = 1'b0;
    scan_in     = 1'b0;
    error_found = 4'd0;
    reset       = 1'b0;
    // Nonzero inputs while in reset must be ignored.
    for (int i = 0; i < 4; i++) begin
      cmd[i] = 4'd1;
      din[i] = 32'h1234_5678;
    end
    repeat (3) @(negedge c_clk);
    chk_all("reset", 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);
    chk("reset_scan_out", 32'(scan_out), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cmd[i] = 4'd0;
      din[i] = 32'd0;
    end
    reset = 1'b1;
    @(negedge c_clk);
    chk_all("post_reset", 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);

    // Basic arithmetic.
    txn("p1_add",     0, 4'd1, 32'h0000_001A, 32'h0000_0005, 2'd1, 32'h0000_001F);
    txn("p4_add",     3, 4'd1, 32'h4A0F_58D4, 32'h0000_F03E, 2'd1, 32'h4A10_4912);
    txn("p4_add_ovf", 3, 4'd1, 32'hFFFF_FFFE, 32'h0000_0002, 2'd2, 32'h0000_0000);
    txn("p2_sub_eq",  1, 4'd2, 32'd5,         32'd5,         2'd1, 32'h0000_0000);
    txn("p3_sub_und", 2, 4'd2, 32'd5,         32'd10,        2'd2, 32'h0000_0000);
    txn("p3_sub",     2, 4'd2, 32'd100,       32'd58,        2'd1, 32'd42);

    // Shifts: only the low five bits of operand2 are used as the amount.
    txn("shl_1",  0, 4'd5, 32'hCDE1_056E, 32'h0000_0101, 2'd1, 32'h9BC2_0ADC);
    txn("shl_0",  0, 4'd5, 32'hCDE1_056E, 32'h0000_0000, 2'd1, 32'hCDE1_056E);
    txn("shr_1",  1, 4'd6, 32'hCDE1_056E, 32'h0000_0101, 2'd1, 32'h66F0_82B7);
    txn("shr_31", 3, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001);

    // Four adds in the same cycle are served in port order, one per cycle.
    @(negedge c_clk);
    cmd = '{4'd1, 4'd1, 4'd1, 4'd1};
    din = '{32'd10, 32'd1000000, 32'hFFFF_FFFE, 32'h000F_FFFF};
    @(negedge c_clk);
    cmd = '{4'd0, 4'd0, 4'd0, 4'd0};
    din = '{32'd25, 32'd2000000, 32'd2, 32'd5};
    @(negedge c_clk);
    din = '{32'd0, 32'd0, 32'd0, 32'd0};
    @(negedge c_clk);
    chk_all("cont_c1", 2'd1, 32'd35, 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);
    @(negedge c_clk);
    chk_all("cont_c2", 2'd0, 32'd0, 2'd1, 32'd3000000, 2'd0, 32'd0, 2'd0, 32'd0);
    @(negedge c_clk);
    chk_all("cont_c3", 2'd0, 32'd0, 2'd0, 32'd0, 2'd2, 32'd0, 2'd0, 32'd0);
    @(negedge c_clk);
    chk_all("cont_c4", 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0, 2'd1, 32'h0010_0004);
    @(negedge c_clk);
    chk_all("cont_idle", 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);
    txn("p3_shl_after", 2, 4'd5, 32'h0000_0001, 32'h0000_0004, 2'd1, 32'h0000_0010);

    // An add and a shift use different units, so they answer together.
    @(negedge c_clk);
    cmd[0] = 4'd1; din[0] = 32'd7;
    cmd[1] = 4'd6; din[1] = 32'hF000_0000;
    @(negedge c_clk);
    cmd[0] = 4'd0; din[0] = 32'd8;
    cmd[1] = 4'd0; din[1] = 32'd4;
    @(negedge c_clk);
    din[0] = 32'd0; din[1] = 32'd0;
    @(negedge c_clk);
    chk_all("par", 2'd1, 32'd15, 2'd1, 32'h0F00_0000, 2'd0, 32'd0, 2'd0, 32'd0);

    // An invalid command answers with code 3 and zero data.
    txn("p1_inv", 0, 4'd7, 32'h2309_ABEF, 32'h3322_00FF, 2'd3, 32'h0000_0000);

    // A reset in the middle of a request discards it.
    issue(0, 4'd1, 32'd1, 32'd2);
    reset = 1'b0;
    #1;
    chk_all("mid_reset", 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0, 2'd0, 32'd0);
    @(negedge c_clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge c_clk);
      chk("after_reset_resp1", 32'(resp[0]), 32'd0);
      chk("after_reset_data1", dout[0], 32'd0);
    end

    // The port accepts new work after the reset.
    txn("p1_add_after_rst", 0, 4'd1, 32'd3, 32'd4, 2'd1, 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
